// File: rtl/regfile_dump_ctrl_if.sv
// Purpose : debug register-dump bus between the debug unit (master) and the
//           dump sequencer (slave): start/abort control, rs read port, byte stream.
// Ports   : i_start/i_abort control, i_reg_data/o_reg_addr rs read port,
//           o_tx_data/o_tx_valid/i_tx_ready byte stream, o_busy/o_done status.
interface regfile_dump_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  i_start;
  logic                  i_abort;
  logic [DATA_WIDTH-1:0] i_reg_data;
  logic                  i_tx_ready;
  logic [ADDR_WIDTH-1:0] o_reg_addr;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  o_busy;
  logic                  o_done;

  // Debug unit / register file / UART side
  modport master (
    output i_start, i_abort, i_reg_data, i_tx_ready,
    input  o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );

  // Dump sequencer side
  modport slave (
    input  i_start, i_abort, i_reg_data, i_tx_ready,
    output o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Purpose     : walks the register file through the rs read port and streams every
//               register MSB byte first onto a byte-wide valid/ready link.
// Latency     : 6 cycles per register with the sink always ready (ADDR, LOAD, 4 bytes).
// Backpressure: holds o_tx_data/o_tx_valid stable while i_tx_ready is low.
// Ports       : clk, i_rst_n (async active-low), bus (slave modport of regfile_dump_ctrl_if).
module regfile_dump_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  regfile_dump_ctrl_if.slave bus
);

  localparam int BYTES_PER_REG = DATA_WIDTH / 8;
  localparam int BC_W          = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [BC_W-1:0]       byte_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic last_byte;
  logic last_reg;

  assign last_byte = (byte_cnt == BC_W'(BYTES_PER_REG - 1));
  assign last_reg  = (idx == ADDR_WIDTH'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (state == S_IDLE) begin
      // Start beats abort here; abort alone is a no-op.
      if (bus.i_start) begin
        state <= S_ADDR;
        idx   <= '0;
      end
    end else if (bus.i_abort) begin
      // Abort overrides every transition, even a byte accepted this cycle.
      state    <= S_IDLE;
      idx      <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        // Register file reads on negedge; give the new address a full cycle.
        S_ADDR: state <= S_LOAD;
        S_LOAD: begin
          shift_reg <= bus.i_reg_data;
          byte_cnt  <= '0;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (bus.i_tx_ready) begin
            shift_reg <= shift_reg << 8;
            byte_cnt  <= byte_cnt + 1'b1;
            if (last_byte) begin
              if (last_reg) begin
                state <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_ADDR;
              end
            end
          end
        end
        S_DONE: begin
          idx   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_reg_addr = idx;
  assign bus.o_tx_data  = shift_reg[DATA_WIDTH-1 -: 8];
  assign bus.o_tx_valid = (state == S_SEND);
  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_done     = (state == S_DONE);

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
Debug-side sequencer that walks the 32-entry general-purpose register file through its rs read port. It serialises every register, MSB byte first, onto a byte-wide valid/ready stream toward the debug UART transmitter. The debug unit starts it after halting the pipeline. It owns the rs read address while o_busy is high.

Parameters:
NUM_REGS, 32, number of registers dumped; index runs 0..NUM_REGS-1
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register width; must be a multiple of 8
BYTES_PER_REG, DATA_WIDTH/8, bytes sent per register (4)

Ports:
clk  input  1  system clock; all state changes on posedge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  dump request; sampled only in IDLE
i_abort  input  1  synchronous abort; returns to IDLE with no o_done
i_reg_data  input  DATA_WIDTH  register file rs read data for o_reg_addr
i_tx_ready  input  1  downstream byte sink ready
o_reg_addr  output  ADDR_WIDTH  register index driven to the rs read port
o_tx_data  output  8  byte to transmit
o_tx_valid  output  1  o_tx_data valid
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE, idx=0, byte_cnt=0, shift reg=0, o_reg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
- o_reg_addr always equals idx. o_tx_data always equals shift_reg[DATA_WIDTH-1 -: 8].
- States:
  - IDLE:
    - i_start=1 -> ADDR, idx=0.
  - ADDR:
    - One wait cycle so the register file's negedge read settles for the new address.
    - Always -> LOAD.
  - LOAD:
    - shift_reg<=i_reg_data, byte_cnt<=0.
    - -> SEND.
  - SEND:
    - o_tx_valid=1.
    - On a handshake (o_tx_valid & i_tx_ready): shift_reg<<=8, byte_cnt++.
    - If byte_cnt==BYTES_PER_REG-1 at the handshake:
      - idx==NUM_REGS-1 -> DONE.
      - Otherwise idx++ and -> ADDR.
    - No handshake -> hold the state; o_tx_data and o_tx_valid stay stable.
  - DONE:
    - o_done=1 for exactly this cycle.
    - idx<=0, -> IDLE.
- Latency with i_start sampled at edge E0 and i_tx_ready tied high:
  - o_tx_valid rises after E2.
  - Each register costs 6 edges.
  - The last handshake occurs at E0+192.
  - o_done is high between E0+192 and E0+193.
  - o_busy is high from after E0 until after E0+193.
- i_start in any non-IDLE state, including DONE, is ignored; it is not queued.
- i_abort has priority over all transitions in every non-IDLE state:
  - Next state IDLE, o_tx_valid=0, idx=0, byte_cnt=0.
  - No o_done.
  - A byte offered in the same cycle as i_abort with i_tx_ready=1 counts as accepted by the sink, but the controller discards its progress.
- i_abort in IDLE is a no-op. If i_abort and i_start are both high in IDLE, i_start wins.
- Reset asserted mid-dump: immediate return to reset values. No partial o_done.
- The data width of each byte is fixed at 8; there is no wrap of idx past NUM_REGS-1.
- The block never writes the register file. It does not gate i_wenable; the debug unit guarantees the pipeline is halted while o_busy is high.

Test Plan:
- Full dump, i_tx_ready=1, register k preloaded with 32'hA5000000+k, single-cycle i_start -> 128 bytes in order A5 00 00 00, A5 00 00 01 ... A5 00 00 1F; o_done pulses once at E0+192; o_busy low after E0+193.
- Backpressure: i_tx_ready toggles 1 cycle on / 2 cycles off -> byte sequence identical to the full-dump case; o_tx_data and o_tx_valid stable during every stall; o_done after the 128th handshake only.
- i_start pulsed during SEND of register 5 and again during DONE -> no restart; exactly 128 bytes and one o_done; IDLE afterwards.
- i_abort during SEND of register 10 byte 2 -> o_tx_valid low next cycle, no o_done, o_reg_addr=0. A following i_start begins again at register 0, byte A5.
- i_rst_n pulled low asynchronously mid-cycle during LOAD of register 3 -> all outputs at reset values immediately. After release, a new dump is full and correct.
- Register 0 returns 0 -> first four bytes are 00 00 00 00; o_reg_addr steps 0..31 and holds each value across the ADDR and LOAD cycles.
